uc_bcast_queue: RTL and testbench
=================================

Name: uc_bcast_queue

Overview:
- Sits directly downstream of the unit-clause arbiter.
- Captures each arbitrated unit literal once and broadcasts it to every BCP engine.
- Each engine consumes the stream at its own pace: single-writer, NUM_ENGINE-reader circular buffer with independent read pointers.
- Returns per-engine full status to the arbiter as backpressure, and supports a one-cycle flush on conflict or restart.

Parameters:
- NUM_ENGINE, default `NUM_ENGINE: number of reader engines.
- DEPTH, default 8: entries in the shared literal store; must be a power of 2 and at least 2.
- LIT_W, default $clog2(`LIT_IDX_MAX)+1: signed literal width, sign is polarity.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- push_valid  in  1  arbiter presents a literal this cycle
- push_lit  in  LIT_W signed  literal from arbiter
- flush  in  1  discard all queued literals
- eng_pop  in  NUM_ENGINE  engine i consumes its head entry
- eng_lit  out  NUM_ENGINE x LIT_W signed  head literal per engine
- eng_empty  out  NUM_ENGINE  engine i has nothing pending
- uca2eng_full  out  NUM_ENGINE  engine i is DEPTH entries behind
- overflow  out  1  sticky: a push was dropped
- drained  out  1  all engines empty

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: wr_ptr=0, all rd_ptr[i]=0, overflow=0. Consequently eng_empty=all 1, uca2eng_full=0, drained=1, eng_lit=0. Store contents are don't-care.
- Pointers: wr_ptr and each rd_ptr[i] are $clog2(DEPTH)+1 bits, with the extra MSB as wrap bit. occ[i] = wr_ptr - rd_ptr[i], modulo 2^($clog2(DEPTH)+1).
- Status (combinational from registers):
  - eng_empty[i] = (occ[i]==0)
  - uca2eng_full[i] = (occ[i]==DEPTH)
  - drained = &eng_empty
- Push acceptance: accepted iff push_valid && push_lit!=0 && ~|uca2eng_full && !flush. An accepted push writes store[wr_ptr index] and increments wr_ptr at the clock edge.
- Literal 0: a push with push_lit==0 is silently ignored. It is not a literal and does not set overflow.
- Dropped push: push_valid && push_lit!=0 && |uca2eng_full && !flush drops the literal and sets overflow. overflow stays set until rst or flush.
- Pop: eng_pop[i] && !eng_empty[i] increments rd_ptr[i]. A pop while empty is ignored; no underflow and no error.
- Read data: first-word-fall-through. eng_lit[i] = store[rd_ptr[i] index] when !eng_empty[i], else 0.
- Latency: a literal accepted at edge N appears on eng_lit of every empty engine in the cycle after edge N. Push-to-visible latency is 1 cycle.
- Simultaneous push and pop on the same engine: both take effect. occ is unchanged and no full/empty glitch occurs.
- Push when some engine is at DEPTH-1 while that engine also pops: the push is accepted. Full is evaluated on registered occ before the pop (conservative), so a push is accepted only when no engine is full at the start of the cycle.
- Full sources: a lagging engine alone raises its own full bit. The writer stalls on the OR of all full bits, but the per-engine bits are exported so the arbiter can pick which engine to serve.
- Wrap-around: pointer arithmetic is modulo 2*DEPTH. No special case at the index wrap; tested over at least 3 full laps.
- Flush: highest priority. At the edge, wr_ptr and all rd_ptr go to 0 and overflow is cleared. A same-cycle push and same-cycle pops are discarded. All engines read empty the cycle after.
- rst during activity: identical to flush. Queued literals are lost.
- Each engine reads every accepted literal exactly once and in push order.

Decomposition:
- Package uc_pkg holds:
  - LIT_W and a typedef for the signed literal, lit_t, shared with the arbiter and the engines
  - the pointer width constant
  - a function lit_valid(lit_t) returning lit!=0
- Sub-module uc_bcast_rdport: one per engine, via generate. It holds rd_ptr and computes occ, empty, full and the head index from wr_ptr.
- The top level holds the store, wr_ptr, accept logic, overflow and drained.

Test Plan (DEPTH=4, NUM_ENGINE=2):
- Reset: after rst, eng_empty=2'b11, uca2eng_full=0, drained=1, overflow=0. Pushing +5 gives eng_lit[0]=eng_lit[1]=+5 in the next cycle.
- Independent readers: push +1,-2,+3. Engine0 pops 3 times and sees +1,-2,+3 then empty. Engine1 has not popped, still shows +1, with drained=0.
- Full/backpressure: push 4 literals with engine1 idle, so uca2eng_full=2'b11. Engine0 drains → full=2'b10. A 5th push is dropped and overflow=1. After engine1 pops once, full=0 and the push is accepted.
- Zero/flush: pushing 0 leaves occ unchanged and overflow=0. Flush in the same cycle as push +7 and eng_pop=2'b11 gives all empty next cycle, overflow cleared, and +7 never appears.
- Wrap: 14 pushes interleaved with same-cycle pops on both engines, including simultaneous push+pop at occ=3. Both engines receive the exact sequence, and full never asserts.
- Pop on empty: eng_pop=2'b01 while empty leaves pointers unchanged. A following push of -9 reads correctly on both engines.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared unit-clause types: signed literal (sign is polarity, 0 is not a literal)
// and queue pointer sizing used by the arbiter, broadcast queue and BCP engines.
`ifndef NUM_ENGINE
`define NUM_ENGINE 2
`endif
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 1023
`endif

package uc_pkg;

  localparam int LIT_W = $clog2(`LIT_IDX_MAX) + 1;

  typedef logic signed [LIT_W-1:0] lit_t;

  localparam int UC_DEPTH_DEFAULT = 8;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W_DEFAULT = ptr_width(UC_DEPTH_DEFAULT);

  function automatic logic lit_valid(input lit_t lit);
    return lit != '0;
  endfunction

endpackage

// File: rtl/uc_bcast_rdport.sv
// One reader of the broadcast queue: owns its read pointer and derives
// occupancy, empty/full status and the store index of its head entry.
module uc_bcast_rdport
  import uc_pkg::*;
#(
  parameter int DEPTH = UC_DEPTH_DEFAULT,
  parameter int PTR_W = ptr_width(DEPTH),
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             pop,
  input  logic [PTR_W-1:0] wr_ptr,
  output logic             empty,
  output logic             full,
  output logic [IDX_W-1:0] head_idx
);

  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] occ;

  always_comb begin
    occ      = wr_ptr - rd_ptr_q;
    empty    = (occ == '0);
    full     = (occ == PTR_W'(DEPTH));
    head_idx = rd_ptr_q[IDX_W-1:0];
  end

  // A pop while empty is harmlessly ignored; flush overrides any pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = '0;
    end else if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uc_bcast_queue.sv
// Single-writer, multi-reader circular buffer that broadcasts every arbitrated
// unit literal to all BCP engines, each consuming at its own pace.
module uc_bcast_queue
  import uc_pkg::*;
#(
  parameter int NUM_ENGINE = `NUM_ENGINE,
  parameter int DEPTH      = 8,
  parameter int LIT_W      = $clog2(`LIT_IDX_MAX) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_valid,
  input  logic signed [LIT_W-1:0] push_lit,
  input  logic                    flush,
  input  logic [NUM_ENGINE-1:0]   eng_pop,
  output logic signed [LIT_W-1:0] eng_lit [NUM_ENGINE],
  output logic [NUM_ENGINE-1:0]   eng_empty,
  output logic [NUM_ENGINE-1:0]   uca2eng_full,
  output logic                    overflow,
  output logic                    drained
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);

  logic [PTR_W-1:0]       wr_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic                   overflow_d;
  logic                   overflow_q;
  logic                   lit_nz;
  logic                   any_full;
  logic                   accept;
  logic                   drop;
  logic [IDX_W-1:0]       head_idx [NUM_ENGINE];
  logic signed [LIT_W-1:0] mem_q   [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENGINE; gi++) begin : g_rd
      uc_bcast_rdport #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .IDX_W (IDX_W)
      ) u_rdport (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .pop      (eng_pop[gi]),
        .wr_ptr   (wr_ptr_q),
        .empty    (eng_empty[gi]),
        .full     (uca2eng_full[gi]),
        .head_idx (head_idx[gi])
      );
    end
  endgenerate

  // Full is judged on registered occupancy, so a same-cycle pop never frees room.
  always_comb begin
    lit_nz   = (push_lit != '0);
    any_full = |uca2eng_full;
    accept   = push_valid && lit_nz && !any_full && !flush;
    drop     = push_valid && lit_nz &&  any_full && !flush;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q | drop;
    if (flush) begin
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Store needs no reset: entries are only visible once a pointer covers them.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= push_lit;
    end
  end

  // First-word-fall-through heads, forced to zero when nothing is pending.
  always_comb begin
    for (int i = 0; i < NUM_ENGINE; i++) begin
      eng_lit[i] = eng_empty[i] ? '0 : mem_q[head_idx[i]];
    end
  end

  assign overflow = overflow_q;
  assign drained  = &eng_empty;

endmodule

// File: tb/tb_uc_bcast_queue.sv
// Scoreboard bench for uc_bcast_queue with DEPTH=4 and two engines.
module tb_uc_bcast_queue;
  import uc_pkg::*;

  localparam int NE    = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push_valid = 1'b0;
  lit_t       push_lit = '0;
  logic       flush = 1'b0;
  logic [1:0] eng_pop = 2'b00;
  lit_t       eng_lit [NE];
  logic [1:0] eng_empty;
  logic [1:0] uca2eng_full;
  logic       overflow;
  logic       drained;

  int n_checks = 0;
  int n_fail   = 0;

  lit_t sb0 [$];
  lit_t sb1 [$];
  logic ov_m = 1'b0;

  always #5 clk = ~clk;

  uc_bcast_queue #(
    .NUM_ENGINE (NE),
    .DEPTH      (DEPTH),
    .LIT_W      (LIT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid),
    .push_lit     (push_lit),
    .flush        (flush),
    .eng_pop      (eng_pop),
    .eng_lit      (eng_lit),
    .eng_empty    (eng_empty),
    .uca2eng_full (uca2eng_full),
    .overflow     (overflow),
    .drained      (drained)
  );

  // Drives one cycle and updates the scoreboard with what the queue should do.
  task automatic step(input logic pv, input int lit, input logic fl, input logic [1:0] pop);
    logic full_any;
    push_valid = pv;
    push_lit   = lit_t'(lit);
    flush      = fl;
    eng_pop    = pop;
    full_any   = (sb0.size() == DEPTH) || (sb1.size() == DEPTH);
    if (fl) begin
      sb0.delete();
      sb1.delete();
      ov_m = 1'b0;
    end else begin
      if (pop[0] && sb0.size() > 0) void'(sb0.pop_front());
      if (pop[1] && sb1.size() > 0) void'(sb1.pop_front());
      if (pv && lit != 0) begin
        if (full_any) ov_m = 1'b1;
        else begin
          sb0.push_back(lit_t'(lit));
          sb1.push_back(lit_t'(lit));
        end
      end
    end
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    push_lit   = '0;
    flush      = 1'b0;
    eng_pop    = 2'b00;
    $display("cycle push_v=%0b lit=%0d flush=%0b pop=%b -> empty=%b full=%b ov=%0b lit0=%0d lit1=%0d",
             pv, lit, fl, pop, eng_empty, uca2eng_full, overflow, eng_lit[0], eng_lit[1]);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb0.delete();
    sb1.delete();
    ov_m = 1'b0;
    n_checks++;
    if (eng_empty !== 2'b11) begin n_fail++; $display("FAIL reset_empty: got %b want 11", eng_empty); end
    n_checks++;
    if (uca2eng_full !== 2'b00) begin n_fail++; $display("FAIL reset_full: got %b want 00", uca2eng_full); end
    n_checks++;
    if (drained !== 1'b1) begin n_fail++; $display("FAIL reset_drained: got %b want 1", drained); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    for (int i = 0; i < NE; i++) begin
      n_checks++;
      if (eng_lit[i] !== '0) begin n_fail++; $display("FAIL reset_lit%0d: got %0d want 0", i, eng_lit[i]); end
    end
    step(1'b1, 5, 1'b0, 2'b00);
    for (int i = 0; i < NE; i++) begin
      n_checks++;
      if (eng_lit[i] !== lit_t'(5)) begin n_fail++; $display("FAIL reset_push_lit%0d: got %0d want 5", i, eng_lit[i]); end
    end
    n_checks++;
    if (eng_empty !== 2'b00) begin n_fail++; $display("FAIL reset_push_empty: got %b want 00", eng_empty); end
    step(1'b0, 0, 1'b0, 2'b11);
    n_checks++;
    if (drained !== 1'b1) begin n_fail++; $display("FAIL reset_pop_drained: got %b want 1", drained); end
  endtask

  task automatic test_independent;
    step(1'b1, 1, 1'b0, 2'b00);
    step(1'b1, -2, 1'b0, 2'b00);
    step(1'b1, 3, 1'b0, 2'b00);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (eng_lit[0] !== sb0[0]) begin n_fail++; $display("FAIL indep_e0_pop%0d: got %0d want %0d", k, eng_lit[0], sb0[0]); end
      step(1'b0, 0, 1'b0, 2'b01);
    end
    n_checks++;
    if (eng_empty !== 2'b01) begin n_fail++; $display("FAIL indep_empty: got %b want 01", eng_empty); end
    n_checks++;
    if (eng_lit[1] !== lit_t'(1)) begin n_fail++; $display("FAIL indep_e1_head: got %0d want 1", eng_lit[1]); end
    n_checks++;
    if (drained !== 1'b0) begin n_fail++; $display("FAIL indep_drained: got %b want 0", drained); end
    n_checks++;
    if (eng_lit[0] !== '0) begin n_fail++; $display("FAIL indep_e0_zero: got %0d want 0", eng_lit[0]); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (eng_lit[1] !== sb1[0]) begin n_fail++; $display("FAIL indep_e1_pop%0d: got %0d want %0d", k, eng_lit[1], sb1[0]); end
      step(1'b0, 0, 1'b0, 2'b10);
    end
    n_checks++;
    if (drained !== 1'b1) begin n_fail++; $display("FAIL indep_drained_end: got %b want 1", drained); end
  endtask

  task automatic test_full;
    step(1'b1, 10, 1'b0, 2'b00);
    step(1'b1, -11, 1'b0, 2'b00);
    step(1'b1, 12, 1'b0, 2'b00);
    step(1'b1, -13, 1'b0, 2'b00);
    n_checks++;
    if (uca2eng_full !== 2'b11) begin n_fail++; $display("FAIL full_both: got %b want 11", uca2eng_full); end
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++;
      if (eng_lit[0] !== sb0[0]) begin n_fail++; $display("FAIL full_e0_pop%0d: got %0d want %0d", k, eng_lit[0], sb0[0]); end
      step(1'b0, 0, 1'b0, 2'b01);
    end
    n_checks++;
    if (uca2eng_full !== 2'b10) begin n_fail++; $display("FAIL full_lagging: got %b want 10", uca2eng_full); end
    step(1'b1, 20, 1'b0, 2'b00);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow: got %b want 1", overflow); end
    n_checks++;
    if (eng_empty !== 2'b01) begin n_fail++; $display("FAIL full_drop_empty: got %b want 01", eng_empty); end
    n_checks++;
    if (eng_lit[1] !== sb1[0]) begin n_fail++; $display("FAIL full_e1_pop: got %0d want %0d", eng_lit[1], sb1[0]); end
    step(1'b0, 0, 1'b0, 2'b10);
    n_checks++;
    if (uca2eng_full !== 2'b00) begin n_fail++; $display("FAIL full_released: got %b want 00", uca2eng_full); end
    step(1'b1, 20, 1'b0, 2'b00);
    n_checks++;
    if (eng_lit[0] !== lit_t'(20)) begin n_fail++; $display("FAIL full_accept_e0: got %0d want 20", eng_lit[0]); end
    n_checks++;
    if (uca2eng_full !== {sb1.size() == DEPTH, sb0.size() == DEPTH}) begin
      n_fail++; $display("FAIL full_after_accept: got %b want %b", uca2eng_full, {sb1.size() == DEPTH, sb0.size() == DEPTH});
    end
    n_checks++;
    if (overflow !== ov_m) begin n_fail++; $display("FAIL full_sticky: got %b want %b", overflow, ov_m); end
    step(1'b0, 0, 1'b1, 2'b00);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_flush_ov: got %b want 0", overflow); end
  endtask

  task automatic test_zero_flush;
    step(1'b1, 0, 1'b0, 2'b00);
    n_checks++;
    if (eng_empty !== 2'b11) begin n_fail++; $display("FAIL zero_empty: got %b want 11", eng_empty); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL zero_overflow: got %b want 0", overflow); end
    step(1'b1, 3, 1'b0, 2'b00);
    step(1'b1, 0, 1'b0, 2'b00);
    n_checks++;
    if (eng_lit[1] !== lit_t'(3)) begin n_fail++; $display("FAIL zero_head: got %0d want 3", eng_lit[1]); end
    step(1'b0, 0, 1'b0, 2'b11);
    n_checks++;
    if (eng_empty !== 2'b11) begin n_fail++; $display("FAIL zero_not_queued: got %b want 11", eng_empty); end
    step(1'b1, 4, 1'b0, 2'b00);
    step(1'b1, 7, 1'b1, 2'b11);
    n_checks++;
    if (eng_empty !== 2'b11) begin n_fail++; $display("FAIL flush_empty: got %b want 11", eng_empty); end
    n_checks++;
    if (drained !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL flush_status: got drained=%b ov=%b want drained=1 ov=0", drained, overflow);
    end
    step(1'b0, 0, 1'b0, 2'b00);
    for (int i = 0; i < NE; i++) begin
      n_checks++;
      if (eng_lit[i] !== '0) begin n_fail++; $display("FAIL flush_no7_lit%0d: got %0d want 0", i, eng_lit[i]); end
    end
  endtask

  task automatic test_wrap;
    int lit;
    int full_seen;
    full_seen = 0;
    for (int k = 0; k < 14; k++) begin
      lit = (k % 2 == 1) ? -(k + 30) : (k + 30);
      if (k >= 3) begin
        n_checks++;
        if (eng_lit[0] !== sb0[0] || eng_lit[1] !== sb1[0]) begin
          n_fail++; $display("FAIL wrap_pop%0d: got %0d/%0d want %0d/%0d", k, eng_lit[0], eng_lit[1], sb0[0], sb1[0]);
        end
        step(1'b1, lit, 1'b0, 2'b11);
      end else begin
        step(1'b1, lit, 1'b0, 2'b00);
      end
      if (uca2eng_full !== 2'b00) full_seen++;
    end
    while (sb0.size() > 0) begin
      n_checks++;
      if (eng_lit[0] !== sb0[0] || eng_lit[1] !== sb1[0]) begin
        n_fail++; $display("FAIL wrap_drain: got %0d/%0d want %0d/%0d", eng_lit[0], eng_lit[1], sb0[0], sb1[0]);
      end
      step(1'b0, 0, 1'b0, 2'b11);
    end
    n_checks++;
    if (full_seen != 0) begin n_fail++; $display("FAIL wrap_full_seen: got %0d cycles want 0", full_seen); end
    n_checks++;
    if (drained !== 1'b1) begin n_fail++; $display("FAIL wrap_drained: got %b want 1", drained); end
  endtask

  task automatic test_pop_empty;
    step(1'b0, 0, 1'b0, 2'b01);
    n_checks++;
    if (eng_empty !== 2'b11) begin n_fail++; $display("FAIL popempty_empty: got %b want 11", eng_empty); end
    step(1'b1, -9, 1'b0, 2'b00);
    for (int i = 0; i < NE; i++) begin
      n_checks++;
      if (eng_lit[i] !== lit_t'(-9)) begin n_fail++; $display("FAIL popempty_lit%0d: got %0d want -9", i, eng_lit[i]); end
    end
    n_checks++;
    if (uca2eng_full !== 2'b00 || eng_empty !== 2'b00) begin
      n_fail++; $display("FAIL popempty_status: got full=%b empty=%b want full=00 empty=00", uca2eng_full, eng_empty);
    end
    step(1'b0, 0, 1'b0, 2'b11);
    n_checks++;
    if (drained !== 1'b1) begin n_fail++; $display("FAIL popempty_drained: got %b want 1", drained); end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_full();
    test_zero_flush();
    test_wrap();
    test_pop_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
